sync_lock_controller: RTL and testbench

- Sequences the board synchroniser.
- Latches and drives its configuration: opMode, cnt_n, cnt_m, synch_en.
- Converts a per-pulse trigger into correctly shaped toggle_en strobes.
- Checks the returned synchroStatus against an internal mirror of the n-high-in-m pattern, then declares lock or lock loss.
- Sits between the control-register block and the synchroniser. Works in master mode (self-check) and slave mode (phase hunt on the external line).

---
 rtl/font5_sync_pkg.sv | 40 ++++
 rtl/sync_lock_controller_if.sv | 15 +
 rtl/sync_pattern_model.sv | 31 +++
 rtl/sync_lock_controller.sv | 174 +++++++++++++++++
 tb/tb_sync_lock_controller.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/font5_sync_pkg.sv
// Shared types, defaults and the synchroniser pattern-update rule for the sync lock controller.
package font5_sync_pkg;

  localparam int unsigned CNT_W          = 2;
  localparam int unsigned ERR_W          = 8;
  localparam int unsigned TOG_W_DEF      = 2;
  localparam int unsigned SAMPLE_DLY_DEF = 6;
  localparam int unsigned ARM_CYC_DEF    = 8;
  localparam int unsigned LOCK_CNT_DEF   = 4;
  localparam int unsigned MAX_ERR_DEF    = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_HUNT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  typedef struct packed {
    logic             master;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] m;
  } sync_cfg_t;

  typedef struct packed {
    logic [CNT_W-1:0] ctr;
    logic             synch;
  } model_t;

  // One pulse of the n-high-in-m pattern; the ctr==m test has priority.
  function automatic model_t model_step(input model_t cur, input logic [CNT_W-1:0] n,
                                        input logic [CNT_W-1:0] m);
    model_t nxt;
    nxt.ctr   = (cur.ctr == m) ? '0 : cur.ctr + CNT_W'(1);
    nxt.synch = (cur.ctr == m) ? 1'b1 : ((cur.ctr == n) ? 1'b0 : cur.synch);
    return nxt;
  endfunction

endpackage

// File: rtl/sync_lock_controller_if.sv
// Controller-to-synchroniser link: latched configuration, strobe and returned status.
interface sync_lock_controller_if;
  import font5_sync_pkg::*;

  logic             opMode;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_m;
  logic             synch_en;
  logic             toggle_en;
  logic             sync_status;

  modport master (output opMode, cnt_n, cnt_m, synch_en, toggle_en, input sync_status);
  modport slave  (input opMode, cnt_n, cnt_m, synch_en, toggle_en, output sync_status);

endinterface

// File: rtl/sync_pattern_model.sv
// Internal mirror of the synchroniser ctr/synch pattern; clear > load > advance.
module sync_pattern_model
  import font5_sync_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             advance,
  input  logic [CNT_W-1:0] n,
  input  logic [CNT_W-1:0] m,
  output logic             synch
);

  model_t cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (clear) begin
      cur <= '0;
    end else if (load) begin
      cur <= '{ctr: '0, synch: 1'b1};
    end else if (advance) begin
      cur <= model_step(cur, n, m);
    end
  end

  assign synch = cur.synch;

endmodule

// File: rtl/sync_lock_controller.sv
// Sequences the board synchroniser: latches its config, shapes toggle_en strobes,
// and tracks lock by comparing sampled synchroStatus with the internal pattern mirror.
module sync_lock_controller
  import font5_sync_pkg::*;
#(
  parameter int unsigned TOG_W      = TOG_W_DEF,
  parameter int unsigned SAMPLE_DLY = SAMPLE_DLY_DEF,
  parameter int unsigned ARM_CYC    = ARM_CYC_DEF,
  parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
  parameter int unsigned MAX_ERR    = MAX_ERR_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_enable,
  input  logic                   cfg_master,
  input  logic [CNT_W-1:0]       cfg_n,
  input  logic [CNT_W-1:0]       cfg_m,
  input  logic                   trig,
  input  logic                   clr_flags,
  sync_lock_controller_if.master sync_if,
  output logic                   locked,
  output logic                   lock_lost,
  output logic                   trig_overrun,
  output logic [ERR_W-1:0]       err_cnt,
  output logic [2:0]             state
);

  localparam int unsigned BUSY_W  = $clog2(SAMPLE_DLY + 1);
  localparam int unsigned ARM_W   = $clog2(ARM_CYC + 1);
  localparam int unsigned MCNT_W  = 4;
  localparam int unsigned TOG_END = SAMPLE_DLY - TOG_W + 1;

  state_t            fsm;
  sync_cfg_t         cfg_q;
  logic [BUSY_W-1:0] busy;
  logic [ARM_W-1:0]  arm_cnt;
  logic [MCNT_W-1:0] match_cnt;
  logic [MCNT_W-1:0] err_consec;
  logic              tog_q;
  logic              synch_en_q;
  logic              prev_sample;
  logic              model_synch;

  logic accept;
  logic sample;
  logic match;
  logic hunt_load;

  assign accept    = cfg_enable && (fsm != ST_IDLE) && (busy == '0) && trig;
  assign sample    = cfg_enable && (busy == BUSY_W'(1));
  assign match     = (sync_if.sync_status == model_synch);
  assign hunt_load = sample && (fsm == ST_HUNT) && sync_if.sync_status && !prev_sample;

  sync_pattern_model u_model (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!cfg_enable),
    .load    (hunt_load),
    .advance (accept),
    .n       (cfg_q.n),
    .m       (cfg_q.m),
    .synch   (model_synch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= ST_IDLE;
      cfg_q        <= '0;
      busy         <= '0;
      arm_cnt      <= '0;
      match_cnt    <= '0;
      err_consec   <= '0;
      tog_q        <= 1'b0;
      synch_en_q   <= 1'b0;
      prev_sample  <= 1'b0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      trig_overrun <= 1'b0;
      err_cnt      <= '0;
    end else if (!cfg_enable) begin
      // Run request dropped: abandon any strobe/sample in flight.
      fsm         <= ST_IDLE;
      busy        <= '0;
      arm_cnt     <= '0;
      match_cnt   <= '0;
      err_consec  <= '0;
      tog_q       <= 1'b0;
      synch_en_q  <= 1'b0;
      prev_sample <= 1'b0;
      locked      <= 1'b0;
      if (clr_flags) begin
        lock_lost    <= 1'b0;
        trig_overrun <= 1'b0;
        err_cnt      <= '0;
      end
    end else begin
      // Clears first so that any coinciding set below takes precedence.
      if (clr_flags) begin
        lock_lost    <= 1'b0;
        trig_overrun <= 1'b0;
        err_cnt      <= '0;
      end

      if (accept) begin
        busy  <= BUSY_W'(SAMPLE_DLY);
        tog_q <= 1'b1;
      end else if (busy != '0) begin
        busy <= busy - BUSY_W'(1);
        if (busy == BUSY_W'(TOG_END)) tog_q <= 1'b0;
      end

      if (trig && (fsm != ST_IDLE) && (busy != '0)) trig_overrun <= 1'b1;
      if (sample) prev_sample <= sync_if.sync_status;

      case (fsm)
        ST_IDLE: begin
          fsm        <= ST_ARM;
          synch_en_q <= 1'b1;
          arm_cnt    <= '0;
          cfg_q      <= '{master: cfg_master, n: cfg_n, m: cfg_m};
        end
        ST_ARM: begin
          if (arm_cnt == ARM_W'(ARM_CYC - 1)) fsm <= ST_HUNT;
          else arm_cnt <= arm_cnt + ARM_W'(1);
        end
        ST_HUNT: begin
          if (hunt_load) begin
            fsm       <= ST_VERIFY;
            match_cnt <= '0;
          end
        end
        ST_VERIFY: begin
          if (sample) begin
            if (!match) begin
              fsm <= ST_HUNT;
            end else if (match_cnt == MCNT_W'(LOCK_CNT - 1)) begin
              fsm        <= ST_LOCKED;
              locked     <= 1'b1;
              err_consec <= '0;
            end else begin
              match_cnt <= match_cnt + MCNT_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (sample) begin
            if (match) begin
              err_consec <= '0;
            end else begin
              if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
              if (err_consec == MCNT_W'(MAX_ERR - 1)) begin
                fsm        <= ST_HUNT;
                locked     <= 1'b0;
                lock_lost  <= 1'b1;
                err_consec <= '0;
              end else begin
                err_consec <= err_consec + MCNT_W'(1);
              end
            end
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign sync_if.opMode    = cfg_q.master;
  assign sync_if.cnt_n     = cfg_q.n;
  assign sync_if.cnt_m     = cfg_q.m;
  assign sync_if.synch_en  = synch_en_q;
  assign sync_if.toggle_en = tog_q;
  assign state             = fsm;

endmodule

// File: tb/tb_sync_lock_controller.sv
// Bench for sync_lock_controller: behavioural synchronisers on the link plus a strobe scoreboard.
module tb_sync_lock_controller;
  import font5_sync_pkg::*;

  localparam int unsigned TOG_W      = 2;
  localparam int unsigned SAMPLE_DLY = 6;
  localparam int unsigned ARM_CYC    = 8;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned MAX_ERR    = 2;
  localparam int          SLOT       = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_enable = 1'b0;
  logic       cfg_master = 1'b0;
  logic [1:0] cfg_n = 2'd0;
  logic [1:0] cfg_m = 2'd0;
  logic       trig = 1'b0;
  logic       clr_flags = 1'b0;
  logic       locked, lock_lost, trig_overrun;
  logic [7:0] err_cnt;
  logic [2:0] state;

  sync_lock_controller_if sync_if();

  sync_lock_controller #(
    .TOG_W(TOG_W), .SAMPLE_DLY(SAMPLE_DLY), .ARM_CYC(ARM_CYC),
    .LOCK_CNT(LOCK_CNT), .MAX_ERR(MAX_ERR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_master(cfg_master),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .trig(trig), .clr_flags(clr_flags),
    .sync_if(sync_if), .locked(locked), .lock_lost(lock_lost),
    .trig_overrun(trig_overrun), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Synchroniser update rule, written independently for the external devices.
  function automatic logic [2:0] sync_step(input logic [1:0] c, input logic s,
                                           input logic [1:0] n, input logic [1:0] m);
    logic [1:0] c1;
    c1 = c + 2'd1;
    if (c == m) return 3'b001;
    if (c == n) return {c1, 1'b0};
    return {c1, s};
  endfunction

  // A: synchroniser driven by the DUT (master loopback). B: external line at its own phase.
  logic [1:0] a_ctr = 2'd0, b_ctr = 2'd0, b_ld_ctr = 2'd0;
  logic       a_syn = 1'b0, b_syn = 1'b0, b_ld_syn = 1'b0, tog_d = 1'b0;
  logic       b_load = 1'b0, line_sel = 1'b0, invert = 1'b0;

  always @(posedge clk) begin
    tog_d <= sync_if.toggle_en;
    if (!sync_if.synch_en) {a_ctr, a_syn} <= 3'b000;
    else if (sync_if.toggle_en && !tog_d)
      {a_ctr, a_syn} <= sync_step(a_ctr, a_syn, sync_if.cnt_n, sync_if.cnt_m);
    if (b_load) {b_ctr, b_syn} <= {b_ld_ctr, b_ld_syn};
    else if (sync_if.toggle_en && !tog_d)
      {b_ctr, b_syn} <= sync_step(b_ctr, b_syn, 2'd1, 2'd3);
  end

  assign sync_if.sync_status = (line_sel ? b_syn : a_syn) ^ invert;

  typedef struct { int rise; int width; } strobe_t;
  strobe_t sb[$];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: each toggle_en pulse must match the next expected entry.
  initial begin : mon
    logic    prev;
    int      w;
    strobe_t e;
    prev = 1'b0;
    w = 0;
    e = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (sync_if.toggle_en && !prev) begin
        w = 1;
        check("strobe_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("strobe_rise_cycle", cyc, e.rise);
        end
      end else if (sync_if.toggle_en) begin
        w++;
      end else if (prev) begin
        check("strobe_width", w, e.width);
      end
      prev = sync_if.toggle_en;
    end
  end

  task automatic trig_slot(input int width);
    @(negedge clk);
    trig = 1'b1;
    sb.push_back('{cyc + 1, width});
    @(negedge clk);
    trig = 1'b0;
    repeat (SLOT - 2) @(negedge clk);
  endtask

  task automatic run_trigs(input int k);
    for (int i = 0; i < k; i++) trig_slot(TOG_W);
  endtask

  task automatic wait_state(input logic [2:0] want, input int budget);
    int i;
    i = 0;
    while (state != want && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_state", state, want);
  endtask

  task automatic start_run(input logic master, input logic [1:0] n, input logic [1:0] m);
    @(negedge clk);
    cfg_enable = 1'b0;
    @(negedge clk);
    cfg_master = master;
    cfg_n = n;
    cfg_m = m;
    cfg_enable = 1'b1;
    wait_state(3'(ST_HUNT), 20);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_toggle_en"}, sync_if.toggle_en, 0);
    check({tag, "_synch_en"}, sync_if.synch_en, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_lock_lost"}, lock_lost, 0);
    check({tag, "_overrun"}, trig_overrun, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_opMode"}, sync_if.opMode, 0);
    check({tag, "_cnt_n"}, sync_if.cnt_n, 0);
    check({tag, "_cnt_m"}, sync_if.cnt_m, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Master loopback, n=1 m=3: samples 0,0,0,1 then four matches.
    start_run(1'b1, 2'd1, 2'd3);
    check("cfg_opMode", sync_if.opMode, 1);
    check("cfg_cnt_n", sync_if.cnt_n, 1);
    check("cfg_cnt_m", sync_if.cnt_m, 3);
    check("arm_synch_en", sync_if.synch_en, 1);
    run_trigs(3);
    check("hunt_before_rise", state, 2);
    run_trigs(1);
    check("verify_after_rise", state, 3);
    run_trigs(3);
    check("verify_3_matches", state, 3);
    check("not_locked_yet", locked, 0);
    run_trigs(1);
    check("locked_state", state, 4);
    check("locked_flag", locked, 1);
    check("locked_err_cnt", err_cnt, 0);

    // Inverted line for two samples declares loss, restored line relocks.
    invert = 1'b1;
    run_trigs(1);
    check("err1_cnt", err_cnt, 1);
    check("err1_locked", locked, 1);
    run_trigs(1);
    check("loss_err_cnt", err_cnt, 2);
    check("loss_lock_lost", lock_lost, 1);
    check("loss_locked", locked, 0);
    check("loss_state", state, 2);
    invert = 1'b0;
    run_trigs(12);
    check("relock_state", state, 4);
    check("relock_locked", locked, 1);
    check("relock_err_cnt", err_cnt, 2);
    pulse_clr();
    check("clr_err_cnt", err_cnt, 0);
    check("clr_lock_lost", lock_lost, 0);

    // Second trig 3 cycles after an accepted one: one strobe only, model advanced once.
    @(negedge clk);
    trig = 1'b1;
    sb.push_back('{cyc + 1, TOG_W});
    @(negedge clk);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (SLOT - 5) @(negedge clk);
    check("overrun_flag", trig_overrun, 1);
    check("overrun_locked", locked, 1);
    run_trigs(4);
    check("overrun_no_err", err_cnt, 0);
    check("overrun_state", state, 4);
    pulse_clr();
    check("overrun_clr", trig_overrun, 0);

    // Config change while locked is not picked up.
    cfg_n = 2'd2;
    run_trigs(1);
    check("cnt_n_held", sync_if.cnt_n, 1);
    check("cnt_n_held_locked", locked, 1);
    cfg_n = 2'd1;

    // Slave mode: external line preset mid-pattern.
    b_ld_ctr = 2'd2;
    b_ld_syn = 1'b0;
    b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
    line_sel = 1'b1;
    start_run(1'b0, 2'd1, 2'd3);
    check("slave_opMode", sync_if.opMode, 0);
    run_trigs(8);
    check("slave_state", state, 4);
    check("slave_locked", locked, 1);

    // Degenerate patterns where synch stays high.
    line_sel = 1'b0;
    start_run(1'b1, 2'd3, 2'd1);
    run_trigs(10);
    check("n3m1_state", state, 4);
    check("n3m1_cnt_n", sync_if.cnt_n, 3);
    check("n3m1_cnt_m", sync_if.cnt_m, 1);
    start_run(1'b1, 2'd2, 2'd2);
    run_trigs(10);
    check("n2m2_state", state, 4);
    check("n2m2_locked", locked, 1);

    // Enable dropped while toggle_en is high.
    @(negedge clk);
    trig = 1'b1;
    sb.push_back('{cyc + 1, 1});
    @(negedge clk);
    trig = 1'b0;
    cfg_enable = 1'b0;
    @(negedge clk);
    check("drop_toggle_en", sync_if.toggle_en, 0);
    check("drop_state", state, 0);
    check("drop_synch_en", sync_if.synch_en, 0);
    check("drop_locked", locked, 0);

    // Reset asserted while locked and mid-strobe.
    start_run(1'b1, 2'd2, 2'd2);
    run_trigs(10);
    check("prereset_state", state, 4);
    @(negedge clk);
    trig = 1'b1;
    sb.push_back('{cyc + 1, 1});
    @(negedge clk);
    trig = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (3) @(negedge clk);
    cfg_enable = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
